// File: rtl/pe_types.sv
// Shared types for the pe_array controller: FSM state encoding and the
// bit layout of the control fields inside the pe_array input word.
package pe_types;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StStream,
      StFlush,
      StDrain,
      StDone
   } pe_state_e;

   localparam int unsigned ArrLoadBit  = 0;
   localparam int unsigned ArrFlushBit = 1;
   localparam int unsigned ArrAddrLsb  = 2;

endpackage

// File: rtl/pe_ctrl_counter.sv
// Clearable up-counter with an equality compare against a run-time limit.
module pe_ctrl_counter #(
   parameter int unsigned Width = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [Width-1:0] limit_i,
   output logic [Width-1:0] count_o,
   output logic             last_o
);

   logic [Width-1:0] count_d, count_q;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign last_o  = (count_q == limit_i);

endmodule

// File: rtl/pe_array_ctrl.sv
// Job sequencer for the pe_array: loads filters, streams feature vectors,
// flushes the array and waits (bounded) for outstanding results.
module pe_array_ctrl
   import pe_types::*;
#(
   parameter int unsigned RAM_ADDR_WIDTH   = 9,
   parameter int unsigned VEC_CNT_WIDTH    = 16,
   parameter int unsigned NUM_FLUSH_CYCLES = 4,
   parameter int unsigned DRAIN_LATENCY    = 32
) (
   input  logic                      clock,
   input  logic                      resetn,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [RAM_ADDR_WIDTH-1:0] cmd_num_filters,
   input  logic [VEC_CNT_WIDTH-1:0]  cmd_num_vecs,
   input  logic                      src_valid,
   output logic                      src_ready,
   output logic                      arr_ivalid,
   output logic                      arr_load,
   output logic                      arr_flush,
   output logic [RAM_ADDR_WIDTH-1:0] arr_addr,
   input  logic                      arr_ovalid,
   output logic                      busy,
   output logic                      done,
   output logic                      timeout
);

   localparam int unsigned FlushW = $clog2(NUM_FLUSH_CYCLES + 1);
   localparam int unsigned DrainW = $clog2(DRAIN_LATENCY + 1);
   localparam int unsigned WordW  = RAM_ADDR_WIDTH + ArrAddrLsb;

   pe_state_e                 state_d, state_q;
   logic [RAM_ADDR_WIDTH-1:0] num_filters_d, num_filters_q;
   logic [VEC_CNT_WIDTH-1:0]  num_vecs_d, num_vecs_q;
   logic [VEC_CNT_WIDTH:0]    pending_d, pending_q;
   logic                      timeout_d, timeout_q;
   logic [WordW-1:0]          ctrl_word;
   logic                      cmd_fire, stream_beat, pend_dec;
   logic [RAM_ADDR_WIDTH-1:0] load_cnt;
   logic [VEC_CNT_WIDTH-1:0]  vec_cnt;
   logic [FlushW-1:0]         flush_cnt;
   logic [DrainW-1:0]         drain_cnt;
   logic                      load_last, vec_last, flush_last, drain_last;
   logic                      unused_cnt;

   assign cmd_fire    = (state_q == StIdle) && cmd_valid && resetn;
   assign stream_beat = (state_q == StStream) && src_valid;
   // A result arriving with a new beat cancels it out even when nothing is outstanding.
   assign pend_dec    = arr_ovalid && ((pending_q != '0) || stream_beat);

   always_comb begin
      state_d       = state_q;
      num_filters_d = num_filters_q;
      num_vecs_d    = num_vecs_q;
      timeout_d     = timeout_q;
      cmd_ready     = 1'b0;
      src_ready     = 1'b0;
      arr_ivalid    = 1'b0;
      ctrl_word     = '0;
      busy          = 1'b1;
      done          = 1'b0;
      unique case (state_q)
         StIdle: begin
            busy      = 1'b0;
            cmd_ready = resetn;
            if (cmd_fire) begin
               num_filters_d = cmd_num_filters;
               num_vecs_d    = cmd_num_vecs;
               timeout_d     = 1'b0;
               if (cmd_num_filters != '0) begin
                  state_d = StLoad;
               end else if (cmd_num_vecs != '0) begin
                  state_d = StStream;
               end else begin
                  state_d = StFlush;
               end
            end
         end
         StLoad: begin
            src_ready                                = 1'b1;
            arr_ivalid                               = src_valid;
            ctrl_word[ArrLoadBit]                    = 1'b1;
            ctrl_word[ArrAddrLsb +: RAM_ADDR_WIDTH] = load_cnt;
            if (src_valid && load_last) begin
               state_d = (num_vecs_q != '0) ? StStream : StFlush;
            end
         end
         StStream: begin
            src_ready  = 1'b1;
            arr_ivalid = src_valid;
            if (src_valid && vec_last) begin
               state_d = StFlush;
            end
         end
         StFlush: begin
            arr_ivalid             = 1'b1;
            ctrl_word[ArrFlushBit] = 1'b1;
            if (flush_last) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (pending_q == '0) begin
               state_d = StDone;
            end else if (drain_last) begin
               timeout_d = 1'b1;
               state_d   = StDone;
            end
         end
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      pending_d = pending_q;
      if (stream_beat && !pend_dec) begin
         pending_d = pending_q + 1'b1;
      end else if (!stream_beat && pend_dec) begin
         pending_d = pending_q - 1'b1;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q       <= StIdle;
         num_filters_q <= '0;
         num_vecs_q    <= '0;
         pending_q     <= '0;
         timeout_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         num_filters_q <= num_filters_d;
         num_vecs_q    <= num_vecs_d;
         pending_q     <= pending_d;
         timeout_q     <= timeout_d;
      end
   end

   pe_ctrl_counter #(.Width(RAM_ADDR_WIDTH)) u_load_cnt (
      .clk_i   (clock),
      .rst_ni  (resetn),
      .clr_i   (cmd_fire),
      .en_i    ((state_q == StLoad) && src_valid),
      .limit_i (num_filters_q - 1'b1),
      .count_o (load_cnt),
      .last_o  (load_last)
   );

   pe_ctrl_counter #(.Width(VEC_CNT_WIDTH)) u_vec_cnt (
      .clk_i   (clock),
      .rst_ni  (resetn),
      .clr_i   (cmd_fire),
      .en_i    (stream_beat),
      .limit_i (num_vecs_q - 1'b1),
      .count_o (vec_cnt),
      .last_o  (vec_last)
   );

   pe_ctrl_counter #(.Width(FlushW)) u_flush_cnt (
      .clk_i   (clock),
      .rst_ni  (resetn),
      .clr_i   (cmd_fire),
      .en_i    (state_q == StFlush),
      .limit_i (FlushW'(NUM_FLUSH_CYCLES - 1)),
      .count_o (flush_cnt),
      .last_o  (flush_last)
   );

   pe_ctrl_counter #(.Width(DrainW)) u_drain_cnt (
      .clk_i   (clock),
      .rst_ni  (resetn),
      .clr_i   (cmd_fire),
      .en_i    (state_q == StDrain),
      .limit_i (DrainW'(DRAIN_LATENCY - 1)),
      .count_o (drain_cnt),
      .last_o  (drain_last)
   );

   // Only the compare outputs of these counters are needed.
   assign unused_cnt = ^{vec_cnt, flush_cnt, drain_cnt};

   assign arr_load  = ctrl_word[ArrLoadBit];
   assign arr_flush = ctrl_word[ArrFlushBit];
   assign arr_addr  = ctrl_word[ArrAddrLsb +: RAM_ADDR_WIDTH];
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Scoreboard bench for pe_array_ctrl: expected load addresses and job
// descriptors are queued at command time and retired as the DUT acts.
module tb_pe_array_ctrl;

   localparam int unsigned AW       = 9;
   localparam int unsigned VW       = 16;
   localparam int unsigned NumFlush = 4;
   localparam int unsigned DrainLat = 32;

   typedef struct {
      int nf;
      int nv;
   } job_t;

   logic          clock;
   logic          resetn;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [AW-1:0] cmd_num_filters;
   logic [VW-1:0] cmd_num_vecs;
   logic          src_valid;
   logic          src_ready;
   logic          arr_ivalid;
   logic          arr_load;
   logic          arr_flush;
   logic [AW-1:0] arr_addr;
   logic          arr_ovalid;
   logic          busy;
   logic          done;
   logic          timeout;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   done_count = 0;
   job_t job_q[$];
   int   addr_q[$];

   pe_array_ctrl #(
      .RAM_ADDR_WIDTH   (AW),
      .VEC_CNT_WIDTH    (VW),
      .NUM_FLUSH_CYCLES (NumFlush),
      .DRAIN_LATENCY    (DrainLat)
   ) dut (
      .clock           (clock),
      .resetn          (resetn),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_num_filters (cmd_num_filters),
      .cmd_num_vecs    (cmd_num_vecs),
      .src_valid       (src_valid),
      .src_ready       (src_ready),
      .arr_ivalid      (arr_ivalid),
      .arr_load        (arr_load),
      .arr_flush       (arr_flush),
      .arr_addr        (arr_addr),
      .arr_ovalid      (arr_ovalid),
      .busy            (busy),
      .done            (done),
      .timeout         (timeout)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check_val(tag, {cmd_ready, src_ready, arr_ivalid, arr_load, arr_flush, arr_addr,
                      busy, done, timeout}, 32'd0);
   endtask

   // Monitor with a reference model of outstanding results and drain timing.
   initial begin
      int  pend_m = 0;
      int  beats_n = 0;
      int  flush_n = 0;
      int  drain_n = 0;
      bit  seen_flush = 0;
      bit  saw_src = 0;
      bit  in_drain_prev = 0;
      bit  prev_leave = 0;
      bit  exp_to = 0;
      bit  beat;
      job_t j;
      forever begin
         @(negedge clock);
         if (!resetn) begin
            pend_m = 0; beats_n = 0; flush_n = 0; drain_n = 0;
            seen_flush = 0; saw_src = 0; in_drain_prev = 0; prev_leave = 0;
            job_q.delete();
            addr_q.delete();
         end else begin
            if (in_drain_prev) check_val("done_timing", done, prev_leave);
            in_drain_prev = 0;
            if (src_ready) saw_src = 1;
            beat = arr_ivalid && !arr_load && !arr_flush;
            if (arr_ivalid && arr_load) begin
               if (addr_q.size() == 0) check_val("load_extra_beat", 32'd1, 32'd0);
               else check_val("load_addr", 32'(arr_addr), 32'(addr_q.pop_front()));
            end
            if (beat) beats_n++;
            if (arr_flush) begin
               flush_n++;
               seen_flush = 1;
               check_val("flush_src_ready", src_ready, 1'b0);
            end else if (seen_flush && busy && !done) begin
               drain_n++;
               prev_leave = (pend_m == 0) || (drain_n == DrainLat);
               exp_to = (pend_m != 0);
               in_drain_prev = 1;
            end
            if (done) begin
               if (job_q.size() == 0) begin
                  check_val("done_unexpected", 32'd1, 32'd0);
               end else begin
                  j = job_q.pop_front();
                  check_val("stream_beats", beats_n, j.nv);
                  check_val("flush_cycles", flush_n, NumFlush);
                  check_val("load_addrs_left", addr_q.size(), 32'd0);
                  check_val("src_ready_seen", saw_src, (j.nf + j.nv) != 0);
                  check_val("timeout_at_done", timeout, exp_to);
               end
               beats_n = 0; flush_n = 0; drain_n = 0;
               seen_flush = 0; saw_src = 0;
               done_count++;
            end
            if (beat && arr_ovalid) pend_m = pend_m;
            else if (beat) pend_m++;
            else if (arr_ovalid && pend_m > 0) pend_m--;
         end
      end
   end

   task automatic issue(input int nf, input int nv);
      int   n = 0;
      job_t j;
      while (!cmd_ready && n < 50) begin
         @(posedge clock); #1;
         n++;
      end
      check_val("cmd_ready", cmd_ready, 1'b1);
      j.nf = nf;
      j.nv = nv;
      job_q.push_back(j);
      for (int i = 0; i < nf; i++) addr_q.push_back(i);
      cmd_valid       = 1'b1;
      cmd_num_filters = AW'(nf);
      cmd_num_vecs    = VW'(nv);
      @(posedge clock); #1;
      cmd_valid = 1'b0;
      check_val("busy_after_cmd", busy, 1'b1);
      check_val("timeout_cleared", timeout, 1'b0);
   endtask

   // nov results are returned; with coincide set they ride on stream beats first.
   task automatic run_job(input int nf, input int nv, input bit toggle, input int nov,
                          input bit coincide);
      int start = done_count;
      int beats = 0;
      int sent = 0;
      int cyc = 0;
      int n = 0;
      issue(nf, nv);
      while (beats < nf + nv && cyc < 200) begin
         src_valid  = (toggle && beats < nf) ? (cyc % 2 == 0) : 1'b1;
         arr_ovalid = coincide && beats >= nf && sent < nov;
         if (src_valid && src_ready) begin
            beats++;
            if (arr_ovalid) sent++;
         end else begin
            arr_ovalid = 1'b0;
         end
         @(posedge clock); #1;
         cyc++;
      end
      check_val("beats_accepted", beats, nf + nv);
      src_valid  = 1'b0;
      arr_ovalid = 1'b0;
      while (sent < nov) begin
         arr_ovalid = 1'b1;
         @(posedge clock); #1;
         arr_ovalid = 1'b0;
         sent++;
         @(posedge clock); #1;
      end
      while (done_count == start && n < 300) begin
         @(posedge clock); #1;
         n++;
      end
      check_val("done_seen", done_count != start, 1'b1);
      check_val("idle_ready", cmd_ready, 1'b1);
      check_val("idle_busy", busy, 1'b0);
   endtask

   initial begin
      resetn          = 1'b0;
      cmd_valid       = 1'b0;
      cmd_num_filters = '0;
      cmd_num_vecs    = '0;
      src_valid       = 1'b0;
      arr_ovalid      = 1'b0;
      #12;
      check_outputs_zero("reset_outputs");
      #10;
      resetn = 1'b1;
      @(negedge clock);
      check_val("ready_after_reset", cmd_ready, 1'b1);
      @(posedge clock); #1;

      run_job(4, 3, 1'b0, 3, 1'b0);   // basic load/stream/flush/drain
      run_job(5, 2, 1'b1, 2, 1'b0);   // sparse src_valid during load
      run_job(0, 0, 1'b0, 0, 1'b0);   // straight to flush
      run_job(0, 2, 1'b0, 1, 1'b0);   // one result missing: drain times out
      check_val("timeout_sticky", timeout, 1'b1);
      arr_ovalid = 1'b1;              // stale result while idle
      @(posedge clock); #1;
      arr_ovalid = 1'b0;
      check_val("timeout_sticky_idle", timeout, 1'b1);
      run_job(1, 3, 1'b0, 3, 1'b1);   // results coincide with stream beats
      run_job(3, 0, 1'b0, 0, 1'b0);   // load then straight to flush

      // Reset in the middle of streaming.
      issue(2, 5);
      src_valid = 1'b1;
      repeat (3) begin
         @(posedge clock); #1;
      end
      check_val("mid_stream_ready", src_ready, 1'b1);
      #2;
      resetn = 1'b0;
      #1;
      check_outputs_zero("reset_mid_stream");
      src_valid = 1'b0;
      @(negedge clock);
      #2;
      resetn = 1'b1;
      @(negedge clock);
      check_val("ready_after_mid_reset", cmd_ready, 1'b1);
      check_val("busy_after_mid_reset", busy, 1'b0);
      check_val("no_done_after_reset", done, 1'b0);
      @(posedge clock); #1;

      run_job(2, 2, 1'b0, 2, 1'b0);   // recovery after reset

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, got t=%0t expected < 200000", $time);
      $fatal(1, "bench time limit expired");
   end

endmodule
